// File: rtl/uart_api_pkg.sv
// Shared types and helpers for the UART API transmit path.
// Provides bit-timing helper, word type and serialiser state encoding.
package uart_api_pkg;

    localparam int BYTES_PER_WORD = 4;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_api_tx_if.sv
// Packet request handshake between a host-side producer and uart_api_tx.
// master drives valid/header/words; slave (the framer) drives ready.
interface uart_api_tx_if #(
    parameter int NUM_WORDS = 4
);
    import uart_api_pkg::*;

    logic                       i_valid;
    logic                       o_ready;
    word_t                      i_header;
    logic [NUM_WORDS-1:0][31:0] i_words;

    modport master (
        output i_valid,
        output i_header,
        output i_words,
        input  o_ready
    );

    modport slave (
        input  i_valid,
        input  i_header,
        input  i_words,
        output o_ready
    );

endinterface

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 serialiser: start bit, 8 data bits LSB first, stop bit.
// Ports: i_byte/i_start load a byte, o_tx line, o_byte_done in last stop cycle.
module uart_tx_byte
    import uart_api_pkg::*;
#(
    parameter int CLKS_PER_BIT = 108
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_byte,
    input  logic       i_start,
    output logic       o_tx,
    output logic       o_byte_done
);

    localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("CLKS_PER_BIT must be at least 2");
    end

    tx_state_t     state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          tick;

    assign tick = (timer_q == LAST_TICK);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (i_start) state_d = START;
            START: if (tick) state_d = DATA;
            DATA:  if (tick && bit_q == 3'd7) state_d = STOP;
            STOP:  if (tick) state_d = i_start ? START : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A start request in the last stop cycle chains the next byte
    // with no idle time on the line.
    always_comb begin
        timer_d = timer_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        if (state_q != IDLE) begin
            timer_d = tick ? '0 : timer_q + 1'b1;
        end
        unique case (state_q)
            IDLE: begin
                timer_d = '0;
                if (i_start) begin
                    shift_d = i_byte;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_q == 3'd7) begin
                        tx_d  = 1'b1;
                        bit_d = '0;
                    end else begin
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (i_start) begin
                        shift_d = i_byte;
                        tx_d    = 1'b0;
                    end else begin
                        tx_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign o_tx        = tx_q;
    assign o_byte_done = (state_q == STOP) && tick;

endmodule

// File: rtl/uart_api_tx.sv
// Packet framer: header + NUM_WORDS words sent MSB byte first as 8N1 bytes.
// Ports: api (valid/ready/header/words), o_tx line, o_busy, o_done pulse.
module uart_api_tx
    import uart_api_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 921600,
    parameter int NUM_WORDS  = 4,
    parameter int WORD_WIDTH = 32
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    uart_api_tx_if.slave  api,
    output logic          o_tx,
    output logic          o_busy,
    output logic          o_done
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int TOTAL_BYTES  = BYTES_PER_WORD * (NUM_WORDS + 1);
    localparam int BUF_W        = 8 * TOTAL_BYTES;
    localparam int IDX_W        = $clog2(TOTAL_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL_BYTES - 1);

    if (WORD_WIDTH != 32) begin : g_bad_width
        $error("WORD_WIDTH must be 32");
    end
    if (NUM_WORDS < 1) begin : g_bad_words
        $error("NUM_WORDS must be at least 1");
    end

    logic             busy_q, busy_d;
    logic             start_q, start_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [BUF_W-1:0] buf_q, buf_d;
    logic [BUF_W-1:0] packet;

    logic       ready;
    logic       accept;
    logic       load;
    logic       chain;
    logic       next_byte;
    logic       finish;
    logic       last;
    logic       done;
    logic       byte_done;
    logic       ser_start;
    logic [7:0] ser_byte;

    always_comb begin
        packet = '0;
        packet[BUF_W-1 -: 32] = api.i_header;
        for (int i = 0; i < NUM_WORDS; i++) begin
            packet[BUF_W-1-32*(i+1) -: 32] = api.i_words[i];
        end
    end

    assign last      = (idx_q == LAST_IDX);
    assign done      = byte_done && last;
    assign ready     = !busy_q || done;
    assign accept    = api.i_valid && ready;
    assign load      = accept && !busy_q;
    // Accept during the final stop cycle hands the first byte straight
    // to the serialiser so the next start bit follows without a gap.
    assign chain     = accept && busy_q;
    assign finish    = done && !accept;
    assign next_byte = byte_done && !last;

    assign ser_start = start_q || next_byte || chain;
    assign ser_byte  = chain ? api.i_header[31:24] : buf_q[BUF_W-1 -: 8];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            busy_q  <= 1'b0;
            start_q <= 1'b0;
            idx_q   <= '0;
            buf_q   <= '0;
        end else begin
            busy_q  <= busy_d;
            start_q <= start_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
        end
    end

    // The buffer shifts whenever the serialiser takes its top byte.
    always_comb begin
        busy_d  = busy_q;
        start_d = 1'b0;
        idx_d   = idx_q;
        buf_d   = buf_q;
        unique case (1'b1)
            load: begin
                busy_d  = 1'b1;
                start_d = 1'b1;
                idx_d   = '0;
                buf_d   = packet;
            end
            chain: begin
                idx_d = '0;
                buf_d = packet << 8;
            end
            next_byte: begin
                idx_d = idx_q + 1'b1;
                buf_d = buf_q << 8;
            end
            start_q: begin
                buf_d = buf_q << 8;
            end
            finish: begin
                busy_d = 1'b0;
                idx_d  = '0;
            end
            default: ;
        endcase
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_byte     (ser_byte),
        .i_start    (ser_start),
        .o_tx       (o_tx),
        .o_byte_done(byte_done)
    );

    assign api.o_ready = ready;
    assign o_busy      = busy_q && !done;
    assign o_done      = done;

endmodule

// File: tb/tb_uart_api_tx.sv
// Directed bench for uart_api_tx with UART-decoding scoreboard.
// Runs a default-parameter instance and a NUM_WORDS=1 / 50 MHz instance.
module tb_uart_api_tx;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic tx_a, busy_a, done_a;
    logic tx_b, busy_b, done_b;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int done_cnt_a = 0;
    int done_cnt_b = 0;
    int done_cyc_b = -1;

    logic [7:0] q_a[$];
    logic [7:0] q_b[$];

    int         m_cnt [2] = '{default: 0};
    logic       m_act [2] = '{default: 1'b0};
    logic [7:0] m_sh  [2] = '{default: 8'h00};

    uart_api_tx_if #(.NUM_WORDS(4)) ifa ();
    uart_api_tx_if #(.NUM_WORDS(1)) ifb ();

    uart_api_tx #(
        .CLK_FREQ  (100_000_000),
        .BAUD      (921600),
        .NUM_WORDS (4),
        .WORD_WIDTH(32)
    ) dut_a (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .api    (ifa),
        .o_tx   (tx_a),
        .o_busy (busy_a),
        .o_done (done_a)
    );

    uart_api_tx #(
        .CLK_FREQ  (50_000_000),
        .BAUD      (921600),
        .NUM_WORDS (1),
        .WORD_WIDTH(32)
    ) dut_b (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .api    (ifb),
        .o_tx   (tx_b),
        .o_busy (busy_b),
        .o_done (done_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (done_a === 1'b1) done_cnt_a <= done_cnt_a + 1;
        if (done_b === 1'b1) begin
            done_cnt_b <= done_cnt_b + 1;
            done_cyc_b <= cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push_a(input logic [31:0] h, input logic [3:0][31:0] w);
        for (int k = 3; k >= 0; k--) q_a.push_back(h[8*k +: 8]);
        for (int i = 0; i < 4; i++) begin
            for (int k = 3; k >= 0; k--) q_a.push_back(w[i][8*k +: 8]);
        end
    endtask

    task automatic send_a(input logic [31:0] h, input logic [3:0][31:0] w,
                          output int acc);
        ifa.i_header = h;
        ifa.i_words  = w;
        ifa.i_valid  = 1'b1;
        push_a(h, w);
        @(negedge clk);
        acc = cyc;
        ifa.i_valid = 1'b0;
        chk("accept_ready_low", ifa.o_ready, 0);
        chk("accept_busy_high", busy_a, 1);
    endtask

    task automatic wait_done_a(input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done_a === 1'b1) begin
                at = cyc;
                break;
            end
        end
        chk("done_a_seen", (at >= 0), 1);
    endtask

    // Line decoder: bit b of a byte is sampled mid-bit, stop bit at b=9.
    task automatic mon_step(input int m);
        logic       t;
        int         c;
        logic       have;
        logic [7:0] exp;
        t    = (m == 0) ? tx_a : tx_b;
        c    = (m == 0) ? 108 : 54;
        have = 1'b0;
        exp  = 8'h00;
        if (!rst_n) begin
            m_act[m] = 1'b0;
        end else if (!m_act[m]) begin
            if (t === 1'b0) begin
                m_act[m] = 1'b1;
                m_cnt[m] = 0;
            end
        end else begin
            m_cnt[m]++;
            for (int b = 1; b <= 8; b++) begin
                if (m_cnt[m] == b * c + c / 2) m_sh[m] = {t, m_sh[m][7:1]};
            end
            if (m_cnt[m] == 9 * c + c / 2) begin
                m_act[m] = 1'b0;
                chk($sformatf("mon%0d_stop_bit", m), t, 1);
                if (m == 0) begin
                    have = (q_a.size() > 0);
                    if (have) exp = q_a.pop_front();
                end else begin
                    have = (q_b.size() > 0);
                    if (have) exp = q_b.pop_front();
                end
                checks++;
                assert (have) else begin
                    errors++;
                    $error("FAIL mon%0d_unexpected observed=%0h expected=none",
                           m, m_sh[m]);
                end
                if (have) chk($sformatf("mon%0d_byte", m), m_sh[m], exp);
            end
        end
    endtask

    always begin
        @(negedge clk);
        for (int m = 0; m < 2; m++) mon_step(m);
    end

    initial begin
        logic [3:0][31:0] w1, w2, w3, w4;
        int acc, acc2, acc3, acc4, at, b_acc, low, edges, cnt0;

        w1[0] = 32'h0000_0001;
        w1[1] = 32'h1234_5678;
        w1[2] = 32'hDEAD_BEEF;
        w1[3] = 32'h8000_0000;
        w2[0] = 32'hCAFE_F00D;
        w2[1] = 32'h0F0F_F0F0;
        w2[2] = 32'h5555_AAAA;
        w2[3] = 32'h0123_4567;
        w3[0] = 32'h5566_7700;
        w3[1] = 32'h1111_1111;
        w3[2] = 32'h2222_2222;
        w3[3] = 32'h3333_3333;
        w4[0] = 32'h89AB_CDEF;
        w4[1] = 32'hFEDC_BA98;
        w4[2] = 32'h7654_3210;
        w4[3] = 32'h00FF_00FF;

        ifa.i_valid  = 1'b0;
        ifa.i_header = '0;
        ifa.i_words  = '0;
        ifb.i_valid  = 1'b0;
        ifb.i_header = '0;
        ifb.i_words  = '0;

        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_tx", tx_a, 1);
        chk("rst_ready", ifa.o_ready, 1);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_tx", tx_a, 1);
        chk("idle_ready", ifa.o_ready, 1);

        ifb.i_header = 32'hA5C3_0F81;
        ifb.i_words  = 32'h0123_4567;
        ifb.i_valid  = 1'b1;
        q_b.push_back(8'hA5);
        q_b.push_back(8'hC3);
        q_b.push_back(8'h0F);
        q_b.push_back(8'h81);
        q_b.push_back(8'h01);
        q_b.push_back(8'h23);
        q_b.push_back(8'h45);
        q_b.push_back(8'h67);
        @(negedge clk);
        b_acc = cyc;
        ifb.i_valid = 1'b0;
        chk("b_accept_ready_low", ifb.o_ready, 0);
        chk("b_accept_busy_high", busy_b, 1);

        edges = 0;
        repeat (1000) begin
            @(negedge clk);
            if (tx_a !== 1'b1) edges++;
        end
        chk("idle_tx_quiet", edges, 0);

        for (int i = 0; i < 6000 && done_cnt_b == 0; i++) @(negedge clk);
        chk("b_done_count", done_cnt_b, 1);
        chk("b_done_latency", done_cyc_b - b_acc, 4320);
        chk("b_bytes_all_seen", q_b.size(), 0);
        chk("b_ready_after", ifb.o_ready, 1);
        chk("b_busy_after", busy_b, 0);

        send_a(32'hFFFF_FEFF, w1, acc);
        chk("latency_tx_still_high", tx_a, 1);
        @(negedge clk);
        chk("latency_tx_low", tx_a, 0);
        low = 0;
        while (tx_a === 1'b0 && low < 300) begin
            low++;
            @(negedge clk);
        end
        chk("start_bit_len", low, 108);

        while (cyc < acc + 5000) @(negedge clk);
        ifa.i_header = 32'h0BAD_0BAD;
        ifa.i_words  = '1;
        ifa.i_valid  = 1'b1;
        @(negedge clk);
        ifa.i_valid  = 1'b0;
        chk("ignore_ready_low", ifa.o_ready, 0);
        chk("ignore_busy_high", busy_a, 1);

        while (cyc < acc + 21000) @(negedge clk);
        ifa.i_header = 32'hFFFF_FFFF;
        ifa.i_words  = w2;
        ifa.i_valid  = 1'b1;
        push_a(32'hFFFF_FFFF, w2);
        wait_done_a(2000, at);
        chk("done_latency", at - acc, 21600);
        chk("done_ready", ifa.o_ready, 1);
        chk("done_busy", busy_a, 0);
        chk("done_stop_high", tx_a, 1);
        @(negedge clk);
        acc2 = cyc;
        ifa.i_valid = 1'b0;
        chk("b2b_start_now", tx_a, 0);
        chk("b2b_ready_low", ifa.o_ready, 0);
        chk("b2b_busy_high", busy_a, 1);
        chk("one_done_frame1", done_cnt_a, 1);
        chk("b2b_done_low", done_a, 0);

        wait_done_a(23000, at);
        @(negedge clk);
        chk("two_done_total", done_cnt_a, 2);
        chk("b2b_bytes_all_seen", q_a.size(), 0);
        chk("b2b_accept_cycle", acc2 - acc, 21601);

        repeat (10) @(negedge clk);
        send_a(32'h0102_0304, w3, acc3);
        while (cyc < acc3 + 7 * 1080 + 500) @(negedge clk);
        chk("byte7_line_low", tx_a, 0);
        cnt0 = done_cnt_a;
        rst_n = 1'b0;
        #1;
        chk("midrst_tx_high", tx_a, 1);
        chk("midrst_ready", ifa.o_ready, 1);
        chk("midrst_busy", busy_a, 0);
        q_a.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("midrst_no_done", done_cnt_a, cnt0);
        chk("midrst_tx_idle", tx_a, 1);

        send_a(32'h9ABC_DEF0, w4, acc4);
        wait_done_a(23000, at);
        chk("fresh_done_latency", at - acc4, 21600);
        @(negedge clk);
        chk("fresh_bytes_all_seen", q_a.size(), 0);
        chk("fresh_done_count", done_cnt_a, cnt0 + 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_api_tx.md
Name: uart_api_tx

Overview:
UART transmit framer that returns status and readback packets from the FPGA to the host PC. It is the return path paired with the uart_api_dc receive/parse path. It accepts one packet per handshake: a 32-bit header plus NUM_WORDS 32-bit payload words. It serialises the packet as bytes, MSB byte first, using 8N1 framing on o_tx. Byte order and framing match what the host sends into uart_api_dc.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz
BAUD, 921600, UART bit rate
NUM_WORDS, 4, payload words per packet (>=1)
WORD_WIDTH, 32, header/payload word width; fixed at 32, and any other value is a compile-time error

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  reset, asynchronous assert, active-low
i_valid  in  1  packet request
o_ready  out  1  block can accept a packet
i_header  in  32  packet header word
i_words  in  NUM_WORDS x 32 (packed 2-D)  payload, word 0 sent first
o_tx  out  1  UART TX line, idle high
o_busy  out  1  frame in progress
o_done  out  1  one-cycle pulse when the last stop bit completes

Behaviour:
- One clock domain: i_clk. Reset is asynchronous and active-low on i_rst_n; deassertion is synchronised externally.
- Reset values: o_tx=1, o_ready=1, o_busy=0, o_done=0, all counters 0, state IDLE.
- CLKS_PER_BIT = CLK_FREQ/BAUD, integer truncation. Defaults give 108. Elaboration fails if CLKS_PER_BIT < 2.
- Accept: on the rising edge where i_valid && o_ready, latch i_header and all i_words into a shift buffer. On that same edge o_ready goes to 0 and o_busy goes to 1.
- Byte sequence: header[31:24], [23:16], [15:8], [7:0], then word0 bytes 3..0, through word NUM_WORDS-1.
  - TOTAL_BYTES = 4*(NUM_WORDS+1); this is 20 at defaults.
- Each byte is sent as: start bit (0), data bits LSB first, stop bit (1). Each bit lasts exactly CLKS_PER_BIT cycles.
- No idle gap between bytes; the next start bit follows the stop bit immediately.
- Latency: o_tx falls for the first start bit on the first clock edge after the accept edge.
- Frame length: TOTAL_BYTES*10*CLKS_PER_BIT cycles, which is 21600 at defaults.
- FSM states:
  - IDLE -> START on accept.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> STOP after 8 bits.
  - STOP -> START if bytes remain.
  - STOP -> IDLE after the last byte.
- Counters:
  - bit-timer 0..CLKS_PER_BIT-1, wraps to 0 at the end of each bit.
  - bit index 0..7.
  - byte index 0..TOTAL_BYTES-1, compared against TOTAL_BYTES-1 to detect the last byte.
- Completion, on the STOP -> IDLE edge: o_done=1 for exactly one cycle, o_ready=1, o_busy=0.
- Back-to-back: a packet may be accepted in the same cycle o_done is high. Its start bit then begins on the next edge, giving zero idle bits between packets.
- i_valid while o_ready=0 is ignored. Inputs are not sampled after accept, so changing i_header/i_words mid-frame has no effect.
- Reset mid-frame: o_tx returns to 1 immediately (asynchronous). The partial frame is abandoned, and no o_done is produced for it.
- o_tx is driven from a flop; it is never combinational.

Decomposition:
- Package uart_api_pkg holds:
  - function clks_per_bit(CLK_FREQ, BAUD)
  - localparam BYTES_PER_WORD=4
  - typedef enum tx_state_t {IDLE, START, DATA, STOP}
  - typedef logic [31:0] word_t
- Sub-module uart_tx_byte: single-byte 8N1 serialiser.
  - Interface: i_clk, i_rst_n, i_byte, i_start, o_tx, o_byte_done.
  - Owns the bit-timer and bit index.
- uart_api_tx owns the packet buffer, the byte index and the handshake.

Test Plan:
1. Reset idle: hold i_rst_n=0 for 5 cycles, then release -> o_tx=1, o_ready=1, o_busy=0, o_done=0. No transitions on o_tx for 1000 cycles.
2. Single packet with header 32'hFFFF_FEFF and words {32'h0000_0001, 32'h1234_5678, 32'hDEAD_BEEF, 32'h8000_0000} -> bench UART monitor decodes 20 bytes: FF FF FE FF 00 00 00 01 12 34 56 78 DE AD BE EF 80 00 00 00.
   - Start bit low for exactly 108 cycles.
   - o_done pulses exactly 21600 cycles after the accept edge.
3. Back-to-back: i_valid held high with a second header 32'hFFFF_FFFF -> the second packet is accepted in the o_done cycle, and its first start bit immediately follows the first packet's final stop bit. Bench monitor decodes 40 bytes in order.
4. Busy ignore: pulse i_valid with different data at cycle 5000 of a frame -> no accept, the frame is unchanged, and only one o_done occurs.
5. Reset mid-frame: assert i_rst_n=0 during byte 7 -> o_tx=1 within the same timestep, no o_done. A fresh packet after release transmits correctly.
6. Parameter sweep: NUM_WORDS=1, CLK_FREQ=50_000_000 -> CLKS_PER_BIT=54, 8 bytes per frame, o_done at 4320 cycles.
